peripheral_bus: RTL and testbench
=================================

Name: peripheral_bus

Overview:
- Memory-mapped peripheral block on the single-cycle MIPS data bus, decoding loads and stores in the 0x4000_0000 window.
- Contains a programmable timer, an LED register, a 7-segment digit register, a switch input port and a free-running system tick counter.
- The timer is the interrupt source: its IRQ output drives the IRQ input of the CPU control decoder, which starts exception entry.
- The handler acknowledges the interrupt by clearing the timer status bit through a store.

Parameters:
- BASE_ADDR, 32'h4000_0000, base of the peripheral window.
- LED_W, 8, LED register width.
- SW_W, 8, switch input width.
- DIGI_W, 12, digit register width ({an[3:0], seg[7:0]}).

Ports:
- clk  in  1  system clock, shared with the CPU.
- reset  in  1  asynchronous, active-low reset.
- Addr  in  32  byte address from the ALU.
- WriteData  in  32  store data.
- MemRead  in  1  load strobe.
- MemWrite  in  1  store strobe.
- ReadData  out  32  load data.
- switch  in  SW_W  board switches.
- led  out  LED_W  LED register.
- digi  out  DIGI_W  digit register.
- IRQ  out  1  timer interrupt request to the CPU control decoder.

Behaviour:
- Register map (word offsets from BASE_ADDR):
  - 0x00 TH (RW): timer reload value.
  - 0x04 TL (RW): timer count.
  - 0x08 TCON (RW): bit0 = enable, bit1 = irq_en, bit2 = status; bits 31:3 read 0.
  - 0x0C LED (RW).
  - 0x10 SWITCH (RO): zero-extended.
  - 0x14 DIGI (RW).
  - 0x18 SYSTICK (RO).
- Address decode:
  - Match on Addr[31:5] == BASE_ADDR[31:5] and Addr[4:2].
  - Addr[1:0] are ignored.
  - Unmapped offsets 0x1C–0x1F read 0 and ignore writes.
- Reads:
  - Combinational, zero latency: ReadData is valid in the same cycle as MemRead.
  - ReadData = 0 when MemRead = 0 or the address is outside the window.
- Writes:
  - Committed on the rising clk edge when MemWrite = 1 and the address is mapped.
  - Writes to RO registers are ignored.
- Reset (reset = 0, asynchronous):
  - TH, TL, TCON, LED, DIGI, SYSTICK all clear to 0.
  - Therefore IRQ = 0, led = 0, digi = 0.
  - A reset asserted mid-count aborts the count immediately.
- SYSTICK: increments by 1 every cycle; wraps from 0xFFFF_FFFF to 0.
- Timer, each cycle with TCON.enable = 1:
  - If TL == 0xFFFF_FFFF: TL <= TH (overflow event). Otherwise TL <= TL + 1.
  - With enable = 0, TL holds its value.
- Status:
  - The overflow event sets TCON.status if TCON.irq_en = 1; the current register value is used, not the incoming write.
  - Status is sticky until software writes 0 to bit2.
- IRQ = TCON.status & TCON.irq_en: a registered level with no combinational path from the bus.
- Simultaneous events:
  - A TL write in the same cycle as counting or overflow: the write wins, and no status set occurs from that cycle's overflow.
  - A TCON write in the same cycle as an overflow event: bits 1:0 take WriteData, bit2 = WriteData[2] | overflow-set, so an interrupt is never lost.
  - A TH write in the same cycle as overflow: TL reloads the old TH.
- No state machine beyond the counters. Timer period = (2^32 − TH) cycles.

Decomposition:
- Shared package peripheral_pkg holds:
  - Offset constants: OFF_TH, OFF_TL, OFF_TCON, OFF_LED, OFF_SW, OFF_DIGI, OFF_SYSTICK.
  - TCON bit indices: TCON_EN = 0, TCON_IE = 1, TCON_ST = 2.
- One sub-module, timer_unit, contains TH, TL, TCON, the overflow/reload logic and IRQ generation, with write-enable inputs per register.
- The top level contains the decode logic, the read mux, LED, DIGI and SYSTICK.

Test Plan:
- Reset check: hold reset low, then release; read 0x4000_0008 and 0x4000_0018 at cycle 0 -> 0x0 and 0x0; IRQ = 0.
- Reload:
  - Write TH = 0xFFFF_FFFD, TL = 0xFFFF_FFFD, TCON = 0x3.
  - TL sequence is FFFF_FFFE, FFFF_FFFF, FFFF_FFFD.
  - Status sets on the overflow edge; IRQ = 1 on the following cycle and stays 1.
- Acknowledge:
  - With IRQ = 1, write TCON = 0x3 -> IRQ = 0 next cycle, counting continues.
  - The next overflow sets IRQ again after 3 cycles.
- Simultaneous TCON write and overflow: write TCON = 0x3 on the exact overflow cycle -> TCON reads 0x7, IRQ = 1.
- Masked: TCON = 0x1 and TL overflows -> status stays 0, IRQ = 0, TL reloads TH.
- Misc I/O:
  - switch = 0xA5 -> read 0x4000_0010 returns 0x0000_00A5.
  - Write LED = 0x1FF -> led = 0xFF.
  - Read 0x4000_001C -> 0.
  - MemRead = 0 -> ReadData = 0.

Source files
------------

// File: rtl/peripheral_bus_pkg.sv
// Shared constants for the peripheral window: register word offsets, TCON bit
// positions and a helper that packs the TCON readback word.
package peripheral_pkg;

    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_LED     = 3'd3;
    localparam logic [2:0] OFF_SW      = 3'd4;
    localparam logic [2:0] OFF_DIGI    = 3'd5;
    localparam logic [2:0] OFF_SYSTICK = 3'd6;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    function automatic logic [31:0] tcon_word(input logic en, input logic ie, input logic st);
        tcon_word = {29'd0, st, ie, en};
    endfunction

endpackage

// File: rtl/peripheral_bus_if.sv
// MIPS data-bus signals seen by the peripheral window (CPU is master).
interface peripheral_bus_if;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ReadData;

    modport master (output Addr, output WriteData, output MemRead, output MemWrite, input ReadData);
    modport slave  (input Addr, input WriteData, input MemRead, input MemWrite, output ReadData);
endinterface

// File: rtl/peripheral_bus_timer_unit.sv
// Programmable 32-bit up-counter with reload from TH, sticky status and a
// registered interrupt request.
module timer_unit
    import peripheral_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wdata,
    input  logic        th_we,
    input  logic        tl_we,
    input  logic        tcon_we,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [31:0] tcon,
    output logic        irq
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        st_q, st_d;
    logic        irq_q, irq_d;
    logic        ovf_s;
    logic        st_set_s;

    // Next-state: a bus write to TL beats counting; status sets only from live irq_en.
    always_comb begin
        ovf_s    = en_q && (tl_q == 32'hFFFF_FFFF);
        st_set_s = ovf_s && ie_q && !tl_we;

        if (th_we) begin
            th_d = wdata;
        end else begin
            th_d = th_q;
        end

        if (tl_we) begin
            tl_d = wdata;
        end else if (ovf_s) begin
            tl_d = th_q;
        end else if (en_q) begin
            tl_d = tl_q + 32'd1;
        end else begin
            tl_d = tl_q;
        end

        // An overflow coinciding with a TCON write still lands in status.
        if (tcon_we) begin
            en_d = wdata[TCON_EN];
            ie_d = wdata[TCON_IE];
            st_d = wdata[TCON_ST] | st_set_s;
        end else begin
            en_d = en_q;
            ie_d = ie_q;
            st_d = st_q | st_set_s;
        end

        irq_d = st_d & ie_d;
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th_q  <= 32'd0;
            tl_q  <= 32'd0;
            en_q  <= 1'b0;
            ie_q  <= 1'b0;
            st_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            th_q  <= th_d;
            tl_q  <= tl_d;
            en_q  <= en_d;
            ie_q  <= ie_d;
            st_q  <= st_d;
            irq_q <= irq_d;
        end
    end

    assign th   = th_q;
    assign tl   = tl_q;
    assign tcon = tcon_word(en_q, ie_q, st_q);
    assign irq  = irq_q;

endmodule

// File: rtl/peripheral_bus.sv
// Memory-mapped peripheral window: address decode, zero-latency read mux,
// LED/DIGI registers, switch port, free-running SYSTICK and the timer.
module peripheral_bus
    import peripheral_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          LED_W     = 8,
    parameter int          SW_W      = 8,
    parameter int          DIGI_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    peripheral_bus_if.slave   bus,
    input  logic [SW_W-1:0]   switch,
    output logic [LED_W-1:0]  led,
    output logic [DIGI_W-1:0] digi,
    output logic              IRQ
);

    logic              in_win_s;
    logic [2:0]        off_s;
    logic              wr_s;
    logic              th_we_s, tl_we_s, tcon_we_s, led_we_s, digi_we_s;
    logic [31:0]       th_s, tl_s, tcon_s;
    logic [31:0]       rdata_s;
    logic [LED_W-1:0]  led_q, led_d;
    logic [DIGI_W-1:0] digi_q, digi_d;
    logic [31:0]       systick_q, systick_d;
    logic              unused_s;

    // Byte lanes are not decoded; every access is a full word.
    assign unused_s = ^bus.Addr[1:0];

    assign in_win_s  = (bus.Addr[31:5] == BASE_ADDR[31:5]);
    assign off_s     = bus.Addr[4:2];
    assign wr_s      = bus.MemWrite && in_win_s;
    assign th_we_s   = wr_s && (off_s == OFF_TH);
    assign tl_we_s   = wr_s && (off_s == OFF_TL);
    assign tcon_we_s = wr_s && (off_s == OFF_TCON);
    assign led_we_s  = wr_s && (off_s == OFF_LED);
    assign digi_we_s = wr_s && (off_s == OFF_DIGI);

    timer_unit u_timer (
        .clk     (clk),
        .rst_n   (reset),
        .wdata   (bus.WriteData),
        .th_we   (th_we_s),
        .tl_we   (tl_we_s),
        .tcon_we (tcon_we_s),
        .th      (th_s),
        .tl      (tl_s),
        .tcon    (tcon_s),
        .irq     (IRQ)
    );

    // Next-state for the simple output registers and the tick counter.
    always_comb begin
        if (led_we_s) begin
            led_d = bus.WriteData[LED_W-1:0];
        end else begin
            led_d = led_q;
        end
        if (digi_we_s) begin
            digi_d = bus.WriteData[DIGI_W-1:0];
        end else begin
            digi_d = digi_q;
        end
        systick_d = systick_q + 32'd1;
    end

    // LED, DIGI and SYSTICK registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q     <= {LED_W{1'b0}};
            digi_q    <= {DIGI_W{1'b0}};
            systick_q <= 32'd0;
        end else begin
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
        end
    end

    // Read mux; returns zero outside loads and outside the window.
    always_comb begin
        rdata_s = 32'd0;
        if (bus.MemRead && in_win_s) begin
            case (off_s)
                OFF_TH:      rdata_s = th_s;
                OFF_TL:      rdata_s = tl_s;
                OFF_TCON:    rdata_s = tcon_s;
                OFF_LED:     rdata_s = {{(32-LED_W){1'b0}}, led_q};
                OFF_SW:      rdata_s = {{(32-SW_W){1'b0}}, switch};
                OFF_DIGI:    rdata_s = {{(32-DIGI_W){1'b0}}, digi_q};
                OFF_SYSTICK: rdata_s = systick_q;
                default:     rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.ReadData = rdata_s;
    assign led          = led_q;
    assign digi         = digi_q;

endmodule

// File: tb/tb_peripheral_bus.sv
// Directed bench for peripheral_bus: expected values are queued when a step is
// driven and popped when the DUT output is sampled between clock edges.
module tb_peripheral_bus;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_SW   = 32'h4000_0010;
    localparam logic [31:0] A_DIGI = 32'h4000_0014;
    localparam logic [31:0] A_ST   = 32'h4000_0018;
    localparam logic [31:0] A_UNM  = 32'h4000_001C;

    logic        clk;
    logic        reset;
    logic [7:0]  switch;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        IRQ;
    int          total;
    int          bad;
    logic [31:0] tick_cnt;
    logic [31:0] exp_q[$];

    peripheral_bus_if bus ();

    peripheral_bus dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus.slave),
        .switch (switch),
        .led    (led),
        .digi   (digi),
        .IRQ    (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) tick_cnt <= 32'd0;
        else        tick_cnt <= tick_cnt + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = exp_q.pop_front();
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] obs, input logic [31:0] e);
        exp_q.push_back(e);
        check(tag, obs);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
        bus.Addr    = a;
        bus.MemRead = 1'b1;
        exp_q.push_back(e);
        #1;
        check(tag, bus.ReadData);
        bus.MemRead = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.Addr      = a;
        bus.WriteData = d;
        bus.MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        bus.MemWrite  = 1'b0;
        @(negedge clk);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        switch = 8'h00;
        bus.Addr = 32'd0;
        bus.WriteData = 32'd0;
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk_out("irq_in_reset", {31'd0, IRQ}, 32'd0);
        reset = 1'b1;
        rd(A_TCON, 32'd0, "tcon_reset");
        rd(A_ST, 32'd0, "systick_reset");
        chk_out("irq_reset", {31'd0, IRQ}, 32'd0);
        chk_out("led_reset", {24'd0, led}, 32'd0);
        chk_out("digi_reset", {20'd0, digi}, 32'd0);

        // reload sequence
        wr(A_TH, 32'hFFFF_FFFD);
        wr(A_TL, 32'hFFFF_FFFD);
        wr(A_TCON, 32'h0000_0003);
        rd(A_TL, 32'hFFFF_FFFD, "tl_start");
        step();
        rd(A_TL, 32'hFFFF_FFFE, "tl_seq1");
        chk_out("irq_seq1", {31'd0, IRQ}, 32'd0);
        step();
        rd(A_TL, 32'hFFFF_FFFF, "tl_seq2");
        chk_out("irq_seq2", {31'd0, IRQ}, 32'd0);
        step();
        rd(A_TL, 32'hFFFF_FFFD, "tl_reload");
        rd(A_TCON, 32'h0000_0007, "tcon_status");
        chk_out("irq_set", {31'd0, IRQ}, 32'd1);
        step();
        rd(A_TL, 32'hFFFF_FFFE, "tl_after_reload");
        chk_out("irq_sticky", {31'd0, IRQ}, 32'd1);

        // acknowledge, counting continues, next overflow re-raises
        wr(A_TCON, 32'h0000_0003);
        chk_out("irq_ack", {31'd0, IRQ}, 32'd0);
        rd(A_TL, 32'hFFFF_FFFF, "tl_ack_counts");
        step();
        chk_out("irq_reraise", {31'd0, IRQ}, 32'd1);

        // TCON write on the exact overflow edge keeps the interrupt
        wr(A_TCON, 32'h0000_0003);
        chk_out("irq_clr2", {31'd0, IRQ}, 32'd0);
        step();
        rd(A_TL, 32'hFFFF_FFFF, "tl_pre_simul");
        wr(A_TCON, 32'h0000_0003);
        rd(A_TCON, 32'h0000_0007, "tcon_simul");
        chk_out("irq_simul", {31'd0, IRQ}, 32'd1);

        // masked overflow
        wr(A_TCON, 32'h0000_0001);
        chk_out("irq_masked_clr", {31'd0, IRQ}, 32'd0);
        step();
        step();
        rd(A_TL, 32'hFFFF_FFFD, "tl_masked_reload");
        rd(A_TCON, 32'h0000_0001, "tcon_masked");
        chk_out("irq_masked", {31'd0, IRQ}, 32'd0);

        // TL write beats overflow, no status set
        wr(A_TCON, 32'h0000_0003);
        step();
        wr(A_TL, 32'h0000_0010);
        rd(A_TL, 32'h0000_0010, "tl_write_wins");
        rd(A_TCON, 32'h0000_0003, "tcon_no_set");
        chk_out("irq_tl_wins", {31'd0, IRQ}, 32'd0);

        // TH write on overflow: reload uses old TH
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TH, 32'h0000_0100);
        rd(A_TL, 32'hFFFF_FFFD, "tl_old_th");
        rd(A_TH, 32'h0000_0100, "th_new");
        chk_out("irq_th_ovf", {31'd0, IRQ}, 32'd1);

        // disable holds TL
        wr(A_TCON, 32'h0000_0000);
        chk_out("irq_disable", {31'd0, IRQ}, 32'd0);
        rd(A_TL, 32'hFFFF_FFFE, "tl_last_count");
        step();
        rd(A_TL, 32'hFFFF_FFFE, "tl_hold");

        // misc I/O
        switch = 8'hA5;
        rd(A_SW, 32'h0000_00A5, "switch");
        rd(32'h4000_0013, 32'h0000_00A5, "switch_bytelane");
        wr(A_SW, 32'h0000_0011);
        rd(A_SW, 32'h0000_00A5, "switch_ro");
        wr(A_LED, 32'h0000_01FF);
        chk_out("led_out", {24'd0, led}, 32'h0000_00FF);
        rd(A_LED, 32'h0000_00FF, "led_read");
        wr(A_DIGI, 32'hFFFF_F123);
        chk_out("digi_out", {20'd0, digi}, 32'h0000_0123);
        rd(A_DIGI, 32'h0000_0123, "digi_read");
        wr(A_UNM, 32'hFFFF_FFFF);
        rd(A_UNM, 32'd0, "unmapped_read");
        wr(32'h4000_002C, 32'h0000_0055);
        chk_out("led_outside_win", {24'd0, led}, 32'h0000_00FF);
        rd(32'h4000_002C, 32'd0, "outside_read");
        rd(32'h5000_000C, 32'd0, "other_window");
        rd(A_ST, tick_cnt, "systick_count");
        bus.Addr = A_LED;
        bus.MemRead = 1'b0;
        #1;
        chk_out("memread_low", bus.ReadData, 32'd0);

        // reset mid-count
        wr(A_TCON, 32'h0000_0003);
        step();
        reset = 1'b0;
        #1;
        chk_out("irq_midreset", {31'd0, IRQ}, 32'd0);
        chk_out("led_midreset", {24'd0, led}, 32'd0);
        rd(A_TL, 32'd0, "tl_midreset");
        rd(A_TCON, 32'd0, "tcon_midreset");

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
